ysyx_lsu_resp: RTL and testbench

YSYX_LSU_RESP -- requirements
Module: ysyx_lsu_resp

---
 rtl/ysyx_lsu_resp_pkg.sv | 22 ++
 rtl/ysyx_lsu_resp_mem.sv | 42 ++++
 rtl/ysyx_lsu_resp.sv | 162 ++++++++++++++++
 tb/tb_ysyx_lsu_resp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_lsu_resp_pkg.sv
// Shared LSU response definitions: FSM states, default base address, strobe codes
// and the byte-enable helper.
package ysyx_lsu_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [31:0] LSU_BASE_ADDR = 32'h8000_0000;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0f;

    // Lanes pushed past byte 3 fall off the 4-bit result.
    function automatic logic [3:0] byte_en(input logic [3:0] strb, input logic [1:0] off);
        return strb << off;
    endfunction

endpackage

// File: rtl/ysyx_lsu_resp_mem.sv
// Word-wide backing store with per-byte write enables and one registered read port.
// Only the read register is reset; array contents survive reset.
module ysyx_lsu_resp_mem #(
    parameter int WORDS  = 1024,
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdat_i,
    input  logic [3:0]        wbe_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdat_o
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdat_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdat_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdat_q <= '0;
        end else if (re_i) begin
            rdat_q <= mem_q[raddr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/ysyx_lsu_resp.sv
// LSU responder: accepts one load/store at a time, answers with a one-cycle rvalid/wready pulse.
// YSYX_LSU_RESP_DELAY_EN adds a WAIT state of LATENCY cycles before the response.
module ysyx_lsu_resp
    import ysyx_lsu_resp_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = LSU_BASE_ADDR,
    parameter int                LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    lsu_state_e        state_q;
    logic              is_st_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              rvalid_q;
    logic              wready_q;
    logic [1:0]        rd_off_q;
    logic              rd_oor_q;
`ifdef YSYX_LSU_RESP_DELAY_EN
    localparam logic [15:0] LAT_LAST = 16'(LATENCY - 1);
    logic [15:0]       cnt_q;
`endif

    logic              st_req;
    logic              accept;
    logic              go_resp;
    logic              cur_st;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [3:0]        cur_wstrb;
    logic [ADDR_W-1:0] cur_idx;
    logic [1:0]        cur_off;
    logic              cur_oor;
    logic [DATA_W-1:0] mem_rdat;
    logic              unused_bits;

    assign st_req = lsu_awvalid & lsu_wvalid;
    assign accept = (state_q == ST_IDLE) & (st_req | lsu_arvalid);

    // In IDLE the request comes straight from the ports; afterwards from the latched copy.
    always_comb begin
        cur_st    = is_st_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_wstrb = wstrb_q;
        if (state_q == ST_IDLE) begin
            cur_st    = st_req;
            cur_addr  = st_req ? lsu_awaddr : lsu_araddr;
            cur_wdata = lsu_wdata;
            cur_wstrb = lsu_wstrb[3:0];
        end
    end

    assign cur_idx = (cur_addr - BASE_ADDR) >> 2;
    assign cur_off = cur_addr[1:0];
    assign cur_oor = (cur_addr < BASE_ADDR) | (cur_idx >= ADDR_W'(MEM_WORDS));

`ifdef YSYX_LSU_RESP_DELAY_EN
    assign go_resp = accept ? (LATENCY == 0)
                            : ((state_q == ST_WAIT) && (cnt_q == LAT_LAST));
`else
    assign go_resp = accept;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            is_st_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            rd_off_q <= '0;
            rd_oor_q <= 1'b0;
`ifdef YSYX_LSU_RESP_DELAY_EN
            cnt_q    <= '0;
`endif
        end else begin
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        is_st_q <= st_req;
                        addr_q  <= cur_addr;
                        wdata_q <= lsu_wdata;
                        wstrb_q <= lsu_wstrb[3:0];
`ifdef YSYX_LSU_RESP_DELAY_EN
                        cnt_q   <= '0;
                        state_q <= go_resp ? ST_RESP : ST_WAIT;
`else
                        state_q <= ST_RESP;
`endif
                    end
                end
`ifdef YSYX_LSU_RESP_DELAY_EN
                ST_WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (go_resp) begin
                        state_q <= ST_RESP;
                    end
                end
`endif
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            if (go_resp) begin
                rvalid_q <= ~cur_st;
                wready_q <= cur_st;
                if (!cur_st) begin
                    rd_off_q <= cur_off;
                    rd_oor_q <= cur_oor;
                end
            end
        end
    end

    // The array is touched only on the edge that enters RESP, so an abandoned store never lands.
    ysyx_lsu_resp_mem #(
        .WORDS  (MEM_WORDS),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (go_resp & cur_st & ~cur_oor & ~rst),
        .waddr_i (cur_idx[IDX_W-1:0]),
        .wdat_i  (cur_wdata << {cur_off, 3'b000}),
        .wbe_i   (byte_en(cur_wstrb, cur_off)),
        .re_i    (go_resp & ~cur_st & ~cur_oor & ~rst),
        .raddr_i (cur_idx[IDX_W-1:0]),
        .rdat_o  (mem_rdat)
    );

    // Read register and load offset both change only on a load's RESP edge, so this holds.
    assign lsu_rdata  = rd_oor_q ? '0 : (mem_rdat >> {rd_off_q, 3'b000});
    assign lsu_rvalid = rvalid_q;
    assign lsu_wready = wready_q;

    assign unused_bits = ^{lsu_rstrb, lsu_wstrb[7:4], cur_idx[ADDR_W-1:IDX_W], 32'(LATENCY)};

endmodule

// File: tb/tb_ysyx_lsu_resp.sv
// Bench for ysyx_lsu_resp: directed cases plus random loads/stores against a
// byte-level memory model; response timing follows YSYX_LSU_RESP_DELAY_EN.
module tb_ysyx_lsu_resp;
    import ysyx_lsu_resp_pkg::*;

    localparam int          MEM_WORDS = 1024;
    localparam int          LATENCY   = 2;
    localparam logic [31:0] BASE      = 32'h8000_0000;
`ifdef YSYX_LSU_RESP_DELAY_EN
    localparam int RESP_K = LATENCY + 1;
`else
    localparam int RESP_K = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic [7:0]  lsu_rstrb;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_wvalid;
    logic        lsu_wready;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] mem_m [MEM_WORDS];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    ysyx_lsu_resp #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE),
        .LATENCY   (LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lsu_araddr  (lsu_araddr),
        .lsu_arvalid (lsu_arvalid),
        .lsu_rstrb   (lsu_rstrb),
        .lsu_rdata   (lsu_rdata),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_awaddr  (lsu_awaddr),
        .lsu_awvalid (lsu_awvalid),
        .lsu_wdata   (lsu_wdata),
        .lsu_wstrb   (lsu_wstrb),
        .lsu_wvalid  (lsu_wvalid),
        .lsu_wready  (lsu_wready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < MEM_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a);
        if (!in_range(a)) return 32'h0;
        return mem_m[int'((a - BASE) >> 2)] >> (8 * a[1:0]);
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        int idx;
        int off;
        if (!in_range(a)) return;
        idx = int'((a - BASE) >> 2);
        off = int'(a[1:0]);
        for (int b = 0; b < 4; b++) begin
            if (s[b] && (b + off) < 4) mem_m[idx][8*(b+off) +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic idle_inputs();
        lsu_arvalid = 1'b0;
        lsu_awvalid = 1'b0;
        lsu_wvalid  = 1'b0;
    endtask

    task automatic wait_resp(input bit st, input int exp_k, input logic [31:0] exp_d, input bit scramble);
        bit seen = 1'b0;
        for (int k = 1; k <= exp_k + 4 && !seen; k++) begin
            @(posedge clk); #1;
            if (lsu_rvalid || lsu_wready) begin
                seen = 1'b1;
                check_eq("resp_cycle", k, exp_k);
                check_eq("resp_kind", {30'b0, lsu_rvalid, lsu_wready}, st ? 32'd1 : 32'd2);
                if (!st) check_eq("rdata", lsu_rdata, exp_d);
            end else if (scramble) begin
                lsu_araddr = $urandom;
                lsu_awaddr = $urandom;
                lsu_wdata  = $urandom;
            end
        end
        check_eq("resp_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic txn(input bit st, input logic [31:0] addr, input logic [31:0] data,
                       input logic [7:0] strb, input bit scramble);
        logic [31:0] exp_d;
        @(posedge clk); #1;
        check_eq("pulse_end", {30'b0, lsu_rvalid, lsu_wready}, 32'd0);
        exp_d = model_load(addr);
        if (st) begin
            lsu_awaddr = addr; lsu_wdata = data; lsu_wstrb = strb;
            lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        end else begin
            lsu_araddr = addr; lsu_rstrb = strb; lsu_arvalid = 1'b1;
        end
        wait_resp(st, RESP_K, exp_d, scramble);
        if (st) begin
            model_store(addr, data, strb);
            check_eq("rdata_hold", lsu_rdata, last_rdata);
        end else begin
            last_rdata = exp_d;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        lsu_araddr = '0; lsu_awaddr = '0; lsu_wdata = '0;
        lsu_rstrb = STRB_W; lsu_wstrb = STRB_W;
        last_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rvalid", {31'b0, lsu_rvalid}, 32'd0);
        check_eq("rst_wready", {31'b0, lsu_wready}, 32'd0);
        check_eq("rst_rdata", lsu_rdata, 32'd0);
        rst = 1'b0;

        txn(1, 32'h8000_0004, 32'hDEAD_BEEF, STRB_W, 0);
        txn(0, 32'h8000_0004, 32'h0, STRB_W, 0);
        check_eq("lw_deadbeef", lsu_rdata, 32'hDEAD_BEEF);

        txn(1, 32'h8000_0004, 32'h1122_3344, STRB_W, 1);
        txn(1, 32'h8000_0006, 32'h0000_00AA, STRB_B, 1);
        txn(0, 32'h8000_0004, 32'h0, STRB_W, 1);
        check_eq("sb_merge", lsu_rdata, 32'h11AA_3344);
        txn(0, 32'h8000_0006, 32'h0, STRB_B, 0);
        check_eq("lb_byte", {24'b0, lsu_rdata[7:0]}, 32'hAA);

        // Simultaneous store and load: store wins, load is taken from IDLE afterwards.
        @(posedge clk); #1;
        lsu_awaddr = BASE; lsu_wdata = 32'h5; lsu_wstrb = STRB_W;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        lsu_araddr = BASE; lsu_rstrb = STRB_W; lsu_arvalid = 1'b1;
        wait_resp(1, RESP_K, 32'h0, 0);
        model_store(BASE, 32'h5, STRB_W);
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        wait_resp(0, RESP_K + 1, model_load(BASE), 0);
        check_eq("simul_rdata", lsu_rdata, 32'h5);
        last_rdata = 32'h5;
        idle_inputs();

        txn(0, 32'h7FFF_FFFC, 32'h0, STRB_W, 0);
        check_eq("oor_rdata", lsu_rdata, 32'h0);

        // Reset while a store is in flight: no pulse, no write, memory kept.
        txn(1, BASE + 32'd8, 32'h0BAD_F00D, STRB_W, 0);
        @(posedge clk); #1;
        lsu_awaddr = BASE + 32'd8; lsu_wdata = 32'h1234_5678; lsu_wstrb = STRB_W;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
`ifdef YSYX_LSU_RESP_DELAY_EN
        @(posedge clk); #1;
        check_eq("wait_no_pulse", {30'b0, lsu_rvalid, lsu_wready}, 32'd0);
`endif
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        last_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_no_pulse", {30'b0, lsu_rvalid, lsu_wready}, 32'd0);
            check_eq("rst_rdata_clr", lsu_rdata, 32'd0);
            @(posedge clk); #1;
        end
        txn(0, BASE + 32'd8, 32'h0, STRB_W, 0);
        check_eq("rst_mem_kept", lsu_rdata, 32'h0BAD_F00D);

        for (int w = 0; w < 16; w++) txn(1, BASE + 32'(w * 4), $urandom, STRB_W, 0);
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [7:0]  s;
            case ($urandom_range(0, 2))
                0:       s = STRB_B;
                1:       s = STRB_H;
                default: s = STRB_W;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       a = BASE - 32'd4;
                    1:       a = BASE + 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 3));
                    default: a = 32'h0000_0010;
                endcase
            end else begin
                a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            end
            txn(bit'($urandom_range(0, 1)), a, $urandom, s, 1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
